// File: rtl/falafel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// falafel_pkg : shared widths and types for the falafel core and memory port
// Revision 1.1
// ---------------------------------------------------------------------------
package falafel_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1,
        CAS   = 2'd2
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        RSP     = 3'd5
    } mem_port_state_e;

    // is_cas only has meaning for writes; a read ignores it.
    function automatic mem_op_e decode_op(input logic is_write, input logic is_cas);
        mem_op_e op;
        op = READ;
        if (is_write) begin
            op = is_cas ? CAS : WRITE;
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/falafel_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// falafel_sat_counter : up-counter that sticks at all-ones instead of wrapping
// Revision 1.1
// ---------------------------------------------------------------------------
module falafel_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/falafel_mem_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// falafel_mem_port : one-at-a-time read/write/CAS bridge from core to OBI memory
// Revision 1.1
// ---------------------------------------------------------------------------
module falafel_mem_port #(
    parameter int DATA_W = falafel_pkg::DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_val_i,
    output logic              core_req_rdy_o,
    input  logic              core_req_is_write_i,
    input  logic              core_req_is_cas_i,
    input  logic [DATA_W-1:0] core_req_addr_i,
    input  logic [DATA_W-1:0] core_req_data_i,
    input  logic [DATA_W-1:0] core_req_cas_exp_i,
    output logic              core_rsp_val_o,
    input  logic              core_rsp_rdy_i,
    output logic [DATA_W-1:0] core_rsp_data_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_lock_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [CNT_W-1:0]  cas_fail_cnt_o,
    output logic [CNT_W-1:0]  req_cnt_o
);

    import falafel_pkg::*;

    mem_port_state_e   state_q, state_d;
    mem_op_e           op_q, op_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              cas_fail_inc;
    logic              req_done_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            exp_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            exp_q      <= exp_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        exp_d      = exp_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (core_req_val_i) begin
                    op_d       = decode_op(core_req_is_write_i, core_req_is_cas_i);
                    addr_d     = core_req_addr_i;
                    wdata_d    = core_req_data_i;
                    exp_d      = core_req_cas_exp_i;
                    rsp_data_d = '0;
                    state_d    = (op_d == WRITE) ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ: if (mem_gnt_i) state_d = RD_WAIT;
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    rsp_data_d = mem_rdata_i;
                    state_d    = ((op_q == CAS) && (mem_rdata_i == exp_q)) ? WR_REQ : RSP;
                end
            end
            WR_REQ:  if (mem_gnt_i) state_d = WR_WAIT;
            // A CAS keeps the old value it read as its response.
            WR_WAIT: if (mem_rvalid_i) state_d = RSP;
            RSP:     if (core_rsp_rdy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_req_rdy_o  = (state_q == IDLE);
        core_rsp_val_o  = (state_q == RSP);
        core_rsp_data_o = rsp_data_q;
        mem_req_o       = (state_q == RD_REQ) || (state_q == WR_REQ);
        mem_we_o        = (state_q == WR_REQ);
        mem_addr_o      = addr_q;
        mem_wdata_o     = wdata_q;
        mem_lock_o      = (op_q == CAS) && (state_q != IDLE) && (state_q != RSP);
        cas_fail_inc    = (state_q == RD_WAIT) && mem_rvalid_i && (op_q == CAS)
                          && (mem_rdata_i != exp_q);
        req_done_inc    = (state_q == RSP) && core_rsp_rdy_i;
    end

    falafel_sat_counter #(.CNT_W(CNT_W)) u_cas_fail_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (cas_fail_inc),
        .cnt_o  (cas_fail_cnt_o)
    );

    falafel_sat_counter #(.CNT_W(CNT_W)) u_req_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (req_done_inc),
        .cnt_o  (req_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_falafel_mem_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_falafel_mem_port : scoreboard bench with a behavioural OBI memory
// Revision 1.1
// ---------------------------------------------------------------------------
module tb_falafel_mem_port;
    import falafel_pkg::*;

    localparam int DW = 64;
    localparam int CW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          core_req_val_i = 1'b0;
    logic          core_req_rdy_o;
    logic          core_req_is_write_i = 1'b0;
    logic          core_req_is_cas_i = 1'b0;
    logic [DW-1:0] core_req_addr_i = '0;
    logic [DW-1:0] core_req_data_i = '0;
    logic [DW-1:0] core_req_cas_exp_i = '0;
    logic          core_rsp_val_o;
    logic          core_rsp_rdy_i = 1'b0;
    logic [DW-1:0] core_rsp_data_o;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_we_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_lock_o;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [CW-1:0] cas_fail_cnt_o;
    logic [CW-1:0] req_cnt_o;

    always #5 clk_i = ~clk_i;

    falafel_mem_port #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .core_req_val_i     (core_req_val_i),
        .core_req_rdy_o     (core_req_rdy_o),
        .core_req_is_write_i(core_req_is_write_i),
        .core_req_is_cas_i  (core_req_is_cas_i),
        .core_req_addr_i    (core_req_addr_i),
        .core_req_data_i    (core_req_data_i),
        .core_req_cas_exp_i (core_req_cas_exp_i),
        .core_rsp_val_o     (core_rsp_val_o),
        .core_rsp_rdy_i     (core_rsp_rdy_i),
        .core_rsp_data_o    (core_rsp_data_o),
        .mem_req_o          (mem_req_o),
        .mem_gnt_i          (mem_gnt_i),
        .mem_we_o           (mem_we_o),
        .mem_addr_o         (mem_addr_o),
        .mem_wdata_o        (mem_wdata_o),
        .mem_lock_o         (mem_lock_o),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_rdata_i        (mem_rdata_i),
        .cas_fail_cnt_o     (cas_fail_cnt_o),
        .req_cnt_o          (req_cnt_o)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory seen by the DUT, and the bench's own reference of what it should hold.
    logic [63:0] mem     [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] sb [$];
    int unsigned exp_req = 0;
    int unsigned exp_fail = 0;

    int          gnt_delay = 0;
    int          wait_cnt = 0;
    bit          g_pend = 0, hold_rsp = 0, stale_pend = 0;
    logic [63:0] g_addr = '0, g_wdata = '0;
    logic        g_we = 1'b0;
    int          rd_beats = 0, wr_beats = 0, req_hi = 0, lock_hi = 0, lock_rises = 0;
    bit          lock_prev = 0, req_wait = 0, req_unstable = 0;
    logic [63:0] prev_addr = '0, prev_wdata = '0;
    logic        prev_we = 1'b0;

    // Grant after gnt_delay waiting cycles, answer one cycle after the grant.
    always @(negedge clk_i) begin
        mem_rvalid_i = 1'b0;
        if (g_pend) begin
            if (hold_rsp) begin
                stale_pend = 1;
            end else begin
                mem_rvalid_i = 1'b1;
                if (g_we) begin
                    mem[g_addr] = g_wdata;
                    mem_rdata_i = '0;
                end else begin
                    mem_rdata_i = mem.exists(g_addr) ? mem[g_addr] : 64'h0;
                end
            end
        end else if (stale_pend && !hold_rsp) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = '0;
            stale_pend   = 0;
        end
        g_pend = 0;
        if (req_wait && (!mem_req_o || mem_addr_o !== prev_addr ||
                         mem_wdata_o !== prev_wdata || mem_we_o !== prev_we))
            req_unstable = 1;
        if (mem_req_o) req_hi++;
        if (mem_lock_o) begin
            lock_hi++;
            if (!lock_prev) lock_rises++;
        end
        lock_prev = mem_lock_o;
        mem_gnt_i = 1'b0;
        if (mem_req_o) begin
            if (wait_cnt >= gnt_delay) begin
                mem_gnt_i = 1'b1;
                g_pend    = 1;
                g_addr    = mem_addr_o;
                g_we      = mem_we_o;
                g_wdata   = mem_wdata_o;
                wait_cnt  = 0;
                if (mem_we_o) wr_beats++;
                else rd_beats++;
            end else begin
                wait_cnt++;
            end
        end
        req_wait   = mem_req_o && !mem_gnt_i;
        prev_addr  = mem_addr_o;
        prev_wdata = mem_wdata_o;
        prev_we    = mem_we_o;
    end

    task automatic preload(input logic [63:0] a, input logic [63:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic clear_mon();
        rd_beats = 0; wr_beats = 0; req_hi = 0; lock_hi = 0; lock_rises = 0; req_unstable = 0;
    endtask

    // Called at posedge+1 with the DUT idle; returns cycles from drive to response.
    task automatic do_op(input mem_op_e op, input logic [63:0] addr, input logic [63:0] data,
                         input logic [63:0] cexp, input int rsp_hold, output int lat);
        logic [63:0] old, e, got;
        bit          wr_expected;
        int          n;
        old = ref_mem.exists(addr) ? ref_mem[addr] : 64'h0;
        e = old;
        wr_expected = 0;
        case (op)
            WRITE: begin e = '0; ref_mem[addr] = data; wr_expected = 1; end
            CAS: begin
                if (old == cexp) begin ref_mem[addr] = data; wr_expected = 1; end
                else exp_fail++;
            end
            default: ;
        endcase
        sb.push_back(e);
        clear_mon();
        check("req_rdy_idle", 64'(core_req_rdy_o), 64'd1);
        core_req_val_i      = 1'b1;
        core_req_is_write_i = (op != READ);
        core_req_is_cas_i   = (op == CAS);
        core_req_addr_i     = addr;
        core_req_data_i     = data;
        core_req_cas_exp_i  = cexp;
        @(posedge clk_i); #1;
        core_req_val_i = 1'b0;
        lat = 1;
        n = 0;
        while (!core_rsp_val_o && n < 100) begin
            @(posedge clk_i); #1;
            lat++; n++;
        end
        if (!core_rsp_val_o) begin
            check("rsp_timeout", 64'd0, 64'd1);
            void'(sb.pop_front());
            return;
        end
        got = core_rsp_data_o;
        for (int i = 0; i < rsp_hold; i++) begin
            check("bp_val", 64'(core_rsp_val_o), 64'd1);
            check("bp_data", core_rsp_data_o, got);
            check("bp_req_rdy", 64'(core_req_rdy_o), 64'd0);
            @(posedge clk_i); #1;
        end
        check("lock_in_rsp", 64'(mem_lock_o), 64'd0);
        check("req_rdy_rsp", 64'(core_req_rdy_o), 64'd0);
        core_rsp_rdy_i = 1'b1;
        check("rsp_data", core_rsp_data_o, sb.pop_front());
        exp_req++;
        @(posedge clk_i); #1;
        core_rsp_rdy_i = 1'b0;
        check("rsp_val_drop", 64'(core_rsp_val_o), 64'd0);
        check("req_rdy_after", 64'(core_req_rdy_o), 64'd1);
        check("req_cnt", 64'(req_cnt_o), 64'(exp_req));
        check("cas_fail_cnt", 64'(cas_fail_cnt_o), 64'(exp_fail));
        check("rd_beats", 64'(rd_beats), 64'(op != WRITE));
        check("wr_beats", 64'(wr_beats), 64'(wr_expected));
        check("req_stable", 64'(req_unstable), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_rdy"}, 64'(core_req_rdy_o), 64'd1);
        check({tag, "_rsp_val"}, 64'(core_rsp_val_o), 64'd0);
        check({tag, "_rsp_data"}, core_rsp_data_o, 64'd0);
        check({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we_o), 64'd0);
        check({tag, "_mem_addr"}, mem_addr_o, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 64'd0);
        check({tag, "_mem_lock"}, 64'(mem_lock_o), 64'd0);
        check({tag, "_cas_fail"}, 64'(cas_fail_cnt_o), 64'd0);
        check({tag, "_req_cnt"}, 64'(req_cnt_o), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Read with immediate grant: response in cycle 3, single read beat
        preload(64'h1000, 64'hDEAD);
        gnt_delay = 0;
        do_op(READ, 64'h1000, 64'h0, 64'h0, 0, lat);
        check("read_latency", 64'(lat), 64'd3);
        check("read_req_beats", 64'(req_hi), 64'd1);

        // Write with grant delayed three cycles: request held four cycles
        gnt_delay = 3;
        do_op(WRITE, 64'h2000, 64'h55, 64'h0, 0, lat);
        check("write_req_cycles", 64'(req_hi), 64'd4);
        check("write_mem", mem[64'h2000], 64'h55);

        // CAS success: lock continuous across read and write
        gnt_delay = 0;
        preload(64'h3000, 64'h0);
        do_op(CAS, 64'h3000, 64'h7, 64'h0, 0, lat);
        check("cas_ok_latency", 64'(lat), 64'd5);
        check("cas_ok_lock_cycles", 64'(lock_hi), 64'd4);
        check("cas_ok_lock_rises", 64'(lock_rises), 64'd1);
        check("cas_ok_mem", mem[64'h3000], 64'h7);

        // CAS fail: no write, old value returned
        do_op(CAS, 64'h3000, 64'h9, 64'h0, 0, lat);
        check("cas_fail_latency", 64'(lat), 64'd3);
        check("cas_fail_mem", mem[64'h3000], 64'h7);

        // Response backpressure, then a request accepted right after the handshake
        do_op(READ, 64'h1000, 64'h0, 64'h0, 5, lat);
        do_op(READ, 64'h2000, 64'h0, 64'h0, 0, lat);
        check("after_bp_latency", 64'(lat), 64'd3);

        // CAS with delayed grants on both beats, address passes unaligned
        gnt_delay = 2;
        preload(64'h4005, 64'hABCD);
        do_op(CAS, 64'h4005, 64'h1234, 64'hABCD, 2, lat);
        check("cas_slow_mem", mem[64'h4005], 64'h1234);
        check("cas_slow_lock_rises", 64'(lock_rises), 64'd1);

        // Reset in the middle of a CAS read, then a stale rvalid while idle
        gnt_delay = 0;
        hold_rsp = 1;
        preload(64'h5000, 64'h0);
        clear_mon();
        core_req_val_i      = 1'b1;
        core_req_is_write_i = 1'b1;
        core_req_is_cas_i   = 1'b1;
        core_req_addr_i     = 64'h5000;
        core_req_data_i     = 64'h99;
        core_req_cas_exp_i  = 64'h0;
        @(posedge clk_i); #1;
        core_req_val_i = 1'b0;
        n = 0;
        while (rd_beats == 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("rst_cas_granted", 64'(rd_beats), 64'd1);
        check("rst_cas_lock_before", 64'(mem_lock_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        hold_rsp = 0;
        exp_req = 0;
        exp_fail = 0;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            check("stale_no_rsp", 64'(core_rsp_val_o), 64'd0);
            check("stale_no_req", 64'(mem_req_o), 64'd0);
            check("stale_no_lock", 64'(mem_lock_o), 64'd0);
        end
        check("stale_mem", mem[64'h5000], 64'h0);
        check("stale_rdy", 64'(core_req_rdy_o), 64'd1);

        do_op(READ, 64'h1000, 64'h0, 64'h0, 0, lat);
        check("post_rst_latency", 64'(lat), 64'd3);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/falafel_mem_port.md
Name: falafel_mem_port

Overview:
- Sits directly downstream of falafel_core and terminates its memory request/response handshake.
- Executes read, write and atomic compare-and-swap (CAS) against a single OBI-style memory port (req/gnt, rvalid).
- Holds one transaction in flight at a time.
- A CAS is performed as a locked read followed by a conditional write. The lock keeps the free-list lock word update atomic with respect to other masters behind the memory arbiter.

Parameters:
- DATA_W, falafel_pkg::DATA_W (64): width of address, data and CAS expected value.
- CNT_W, 32: width of the saturating statistics counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_val_i  in  1  request valid from core
- core_req_rdy_o  out  1  port ready to accept request
- core_req_is_write_i  in  1  1 write/CAS, 0 read
- core_req_is_cas_i  in  1  1 CAS (only meaningful when is_write=1)
- core_req_addr_i  in  DATA_W  byte address
- core_req_data_i  in  DATA_W  write data / CAS new value
- core_req_cas_exp_i  in  DATA_W  CAS expected value
- core_rsp_val_o  out  1  response valid to core
- core_rsp_rdy_i  in  1  core ready for response
- core_rsp_data_o  out  DATA_W  response data
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_we_o  out  1  write enable
- mem_addr_o  out  DATA_W  memory address
- mem_wdata_o  out  DATA_W  write data
- mem_lock_o  out  1  arbiter lock, held across the CAS read and write
- mem_rvalid_i  in  1  memory response valid (one per granted request, including writes)
- mem_rdata_i  in  DATA_W  memory read data
- cas_fail_cnt_o  out  CNT_W  saturating count of failed CAS
- req_cnt_o  out  CNT_W  saturating count of completed transactions

Behaviour:
- Reset values: all outputs 0, except core_req_rdy_o = 1 (reset state is IDLE). The FSM returns to IDLE asynchronously.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP.
- IDLE:
  - core_req_rdy_o = 1.
  - On core_req_val_i, latch addr, data, exp and op. Op is decoded as:
    - READ: is_write = 0; is_cas is ignored.
    - WRITE: is_write = 1, is_cas = 0.
    - CAS: is_write = 1, is_cas = 1.
  - READ and CAS go to RD_REQ. WRITE goes to WR_REQ.
- RD_REQ:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = latched addr.
  - mem_lock_o = 1 if the op is CAS.
  - Stay until mem_gnt_i, then go to RD_WAIT.
- RD_WAIT:
  - On mem_rvalid_i, capture rdata into the response register.
  - READ goes to RSP.
  - CAS with rdata == exp goes to WR_REQ.
  - CAS with rdata != exp increments cas_fail_cnt and goes to RSP; no write is issued.
  - mem_lock_o stays 1 for CAS throughout.
- WR_REQ:
  - mem_req_o = 1, mem_we_o = 1, mem_wdata_o = latched data.
  - On mem_gnt_i, go to WR_WAIT.
- WR_WAIT:
  - On mem_rvalid_i, go to RSP.
  - For WRITE the response data is 0. For CAS the response data remains the old value.
  - mem_lock_o drops on the cycle after the CAS write rvalid (i.e. in RSP).
- RSP:
  - core_rsp_val_o = 1 with stable data until core_rsp_rdy_i. Then increment req_cnt and return to IDLE.
  - No back-to-back bypass: the next request is accepted one cycle after the handshake.
- Every request produces exactly one response.
- CAS response = value read. The core detects success by comparing the response with its own expected value.
- Minimum latency with gnt in the same cycle and rvalid one cycle later:
  - Accept at cycle 0, mem_req_o at cycle 1, rvalid at cycle 2, core_rsp_val_o at cycle 3.
  - A successful CAS adds 2 cycles.
- mem_req_o, once raised, stays high with stable address and data until mem_gnt_i; it is never withdrawn.
- mem_rvalid_i arriving in IDLE, *_REQ or RSP is ignored. This covers stale responses after a mid-transaction reset.
- Counters saturate at all-ones and do not wrap.
- A reset during a CAS drops mem_lock_o immediately (asynchronously). The partial transaction is discarded and no response is issued.
- Address alignment is not checked; the address passes through unchanged.

Decomposition:
- falafel_pkg gains:
  - mem_op_e: READ, WRITE, CAS.
  - mem_port_state_e: the six FSM states.
  - Reuse of the existing DATA_W.
- One sub-module, falafel_sat_counter (parameter CNT_W, inc_i, cnt_o), instantiated twice.
- The FSM and datapath stay in falafel_mem_port.

Test Plan:
1. Read: memory holds 0x1000 = 0xDEAD, gnt immediate, rvalid one cycle later -> core_rsp_data_o = 0xDEAD at cycle 3; req_cnt_o = 1; exactly one mem_req_o beat with mem_we_o = 0.
2. Write: addr 0x2000, data 0x55, gnt delayed 3 cycles -> mem_req_o, addr and wdata stable for 4 cycles; response data 0; memory afterwards holds 0x55.
3. CAS success: memory 0x3000 = 0, exp 0, new value 7 -> read then write issued; mem_lock_o high continuously from RD_REQ through WR_WAIT; response 0; memory = 7.
4. CAS fail: memory 0x3000 = 7, exp 0 -> no write beat; response 7; cas_fail_cnt_o = 1.
5. Response backpressure: core_rsp_rdy_i held low for 5 cycles -> core_rsp_val_o and data stable; core_req_rdy_o = 0 throughout; next request accepted one cycle after the handshake.
6. Reset after the CAS read is granted, with a stale rvalid arriving after reset -> outputs return to reset values and mem_lock_o = 0 immediately; the stale rvalid is ignored; no core response; a following read completes normally.
